// File: rtl/sim_usb_channel_pkg.sv
// Shared types for the simulation-only USB packet channel model:
// per-entry tag bits, TX/RX state encodings and the FIFO pointer width helper.
package sim_usb_channel_pkg;

  // A FIFO entry is {tag, data}. The data width is a module parameter, so only
  // the fixed tag part of the entry lives here.
  typedef struct packed {
    logic last;  // entry closes a packet
    logic bad;   // packet must be dropped by the sink
  } entry_tag_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_RECV = 1'b1
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_GAP    = 2'b01,
    RX_STREAM = 2'b10
  } rx_state_e;

  // Pointers carry one extra wrap bit on top of the address bits.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sim_usb_channel_fifo.sv
// Store-and-forward entry RAM for the packet channel. Pointers are one bit wider
// than the address so full and empty are distinguished by the wrap bit. The
// tail-mark port rewrites the most recently written entry's tag to last=1, bad=1
// so an oversize packet can be closed after its overflowing bytes were dropped.
module sim_usb_channel_fifo
  import sim_usb_channel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en_i,
  input  entry_tag_t        wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              tail_mark_i,
  output entry_tag_t        rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] data_mem [DEPTH];
  entry_tag_t        tag_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] tail_addr_s;

  assign tail_addr_s = wr_ptr_q[AW-1:0] - ADDR_ONE;
  assign full_o      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign rd_tag_o    = tag_mem[rd_ptr_q[AW-1:0]];
  assign rd_data_o   = data_mem[rd_ptr_q[AW-1:0]];

  // Pointer advance on write and read; both may happen in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage: normal writes, or tail tag rewrite when closing an oversize packet.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      data_mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
      tag_mem[wr_ptr_q[AW-1:0]]  <= wr_tag_i;
    end else if (tail_mark_i) begin
      tag_mem[tail_addr_s] <= '{last: 1'b1, bad: 1'b1};
    end
  end

endmodule

// File: rtl/sim_usb_packet_channel.sv
// Transaction-level USB packet channel: TX byte source -> store-and-forward FIFO
// -> RX byte sink, with inter-packet gap, RX timeout and delivered-packet count.
// Optional build macro SIM_USB_CHANNEL_ERR_INJ_EN adds errInjArm/errInjIdx to
// corrupt one byte of the next packet and mark that packet bad.
module sim_usb_packet_channel
  import sim_usb_channel_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              txReqSendPacket,
  output logic              txAcceptNewData,
  input  logic              txIsLastByte,
  input  logic              txDataValid,
  input  logic [DATA_W-1:0] txData,
  output logic              sending,
  input  logic              rxAcceptNewData,
  output logic              rxIsLastByte,
  output logic              rxDataValid,
  output logic [DATA_W-1:0] rxData,
  output logic              keepPacket,
  input  logic              resetTimeout,
  output logic              gotTimeout,
  output logic [15:0]       pktCount
`ifdef SIM_USB_CHANNEL_ERR_INJ_EN
  ,
  input  logic              errInjArm,
  input  logic [15:0]       errInjIdx
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] CNT_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [15:0]   GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam rx_state_e     RX_START = (GAP_CYCLES == 0) ? RX_STREAM : RX_GAP;

  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [PW-1:0]     committed_q, committed_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              got_to_q, got_to_d;

  logic              fifo_full_s, fifo_empty_s;
  entry_tag_t        head_tag_s, wr_tag_s;
  logic [DATA_W-1:0] head_data_s, wr_data_s;
  logic              tx_accept_s, tx_xfer_s, tx_commit_s, fifo_wr_s, tail_mark_s;
  logic              rx_valid_s, rx_xfer_s, rx_done_s, more_pending_s;
  logic              inj_flip_s, inj_bad_s;

  // TX handshake: back-pressure only when a committed packet will free space;
  // with nothing committed a full FIFO means an oversize packet, whose excess is dropped.
  assign tx_accept_s = (tx_state_q == TX_RECV) && !(fifo_full_s && (committed_q != CNT_ZERO));
  assign tx_xfer_s   = tx_accept_s && txDataValid;
  assign tx_commit_s = tx_xfer_s && txIsLastByte;
  assign fifo_wr_s   = tx_xfer_s && !fifo_full_s;
  assign tail_mark_s = tx_commit_s && fifo_full_s;

  assign wr_tag_s.last = txIsLastByte;
  assign wr_tag_s.bad  = inj_bad_s;
  assign wr_data_s     = txData ^ {{(DATA_W-1){1'b0}}, inj_flip_s};

  // RX handshake: a committed packet is wholly in the FIFO, so the head is valid while streaming.
  assign rx_valid_s     = (rx_state_q == RX_STREAM) && !fifo_empty_s;
  assign rx_xfer_s      = rx_valid_s && rxAcceptNewData;
  assign rx_done_s      = rx_xfer_s && head_tag_s.last;
  assign more_pending_s = (committed_q > CNT_ONE) || tx_commit_s;

  sim_usb_channel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .wr_en_i     (fifo_wr_s),
    .wr_tag_i    (wr_tag_s),
    .wr_data_i   (wr_data_s),
    .rd_en_i     (rx_xfer_s),
    .tail_mark_i (tail_mark_s),
    .rd_tag_o    (head_tag_s),
    .rd_data_o   (head_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

`ifdef SIM_USB_CHANNEL_ERR_INJ_EN
  logic        inj_armed_q, inj_armed_d, inj_hit_q, inj_hit_d;
  logic [15:0] inj_idx_q, inj_idx_d, byte_idx_q, byte_idx_d;
  logic        inj_match_s;

  assign inj_match_s = inj_armed_q && fifo_wr_s && (byte_idx_q == inj_idx_q);
  assign inj_flip_s  = inj_match_s;
  assign inj_bad_s   = txIsLastByte && (inj_hit_q || inj_match_s);

  // Injection bookkeeping: byte index within the packet, arm consumed at commit.
  always_comb begin
    inj_armed_d = inj_armed_q;
    inj_idx_d   = inj_idx_q;
    inj_hit_d   = inj_hit_q;
    byte_idx_d  = byte_idx_q;
    if (tx_commit_s) begin
      inj_armed_d = 1'b0;
      inj_hit_d   = 1'b0;
      byte_idx_d  = 16'd0;
    end else if (tx_xfer_s) begin
      inj_hit_d  = inj_hit_q || inj_match_s;
      byte_idx_d = byte_idx_q + 16'd1;
    end else begin
      byte_idx_d = byte_idx_q;
    end
    if (errInjArm) begin
      inj_armed_d = 1'b1;
      inj_idx_d   = errInjIdx;
    end else begin
      inj_idx_d   = inj_idx_d;
    end
  end

  // Injection registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      inj_armed_q <= 1'b0;
      inj_idx_q   <= 16'd0;
      inj_hit_q   <= 1'b0;
      byte_idx_q  <= 16'd0;
    end else begin
      inj_armed_q <= inj_armed_d;
      inj_idx_q   <= inj_idx_d;
      inj_hit_q   <= inj_hit_d;
      byte_idx_q  <= byte_idx_d;
    end
  end
`else
  assign inj_flip_s = 1'b0;
  assign inj_bad_s  = 1'b0;
`endif

  // TX FSM next state: request opens a packet, last-byte transfer closes it.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (txReqSendPacket) tx_state_d = TX_RECV;
        else                 tx_state_d = TX_IDLE;
      end
      TX_RECV: begin
        if (tx_commit_s) tx_state_d = TX_IDLE;
        else             tx_state_d = TX_RECV;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX FSM next state. When a packet finishes and another is already committed,
  // go straight into the gap so the sink sees exactly GAP_CYCLES idle cycles.
  always_comb begin
    rx_state_d = rx_state_q;
    gap_cnt_d  = gap_cnt_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (committed_q != CNT_ZERO) begin
          rx_state_d = RX_START;
          gap_cnt_d  = GAP_LOAD;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_GAP: begin
        if (gap_cnt_q == 16'd0) rx_state_d = RX_STREAM;
        else                    gap_cnt_d  = gap_cnt_q - 16'd1;
      end
      RX_STREAM: begin
        if (rx_done_s && more_pending_s) begin
          rx_state_d = RX_START;
          gap_cnt_d  = GAP_LOAD;
        end else if (rx_done_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_STREAM;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Committed-packet and delivered-packet counters; simultaneous commit and completion cancel.
  always_comb begin
    committed_d = committed_q;
    pkt_cnt_d   = pkt_cnt_q;
    case ({tx_commit_s, rx_done_s})
      2'b10:   committed_d = committed_q + CNT_ONE;
      2'b01:   committed_d = committed_q - CNT_ONE;
      default: committed_d = committed_q;
    endcase
    if (rx_done_s) pkt_cnt_d = pkt_cnt_q + 16'd1;
    else           pkt_cnt_d = pkt_cnt_q;
  end

  // Timeout counter: saturating while nothing is available to deliver; sticky flag.
  always_comb begin
    to_cnt_d = to_cnt_q;
    got_to_d = got_to_q;
    if (resetTimeout) begin
      to_cnt_d = {TW{1'b0}};
      got_to_d = 1'b0;
    end else if ((committed_q == CNT_ZERO) && (rx_state_q == RX_IDLE)) begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TO_ONE;
      else                    to_cnt_d = to_cnt_q;
      if (to_cnt_d == TO_MAX) got_to_d = 1'b1;
      else                    got_to_d = got_to_q;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_IDLE;
      committed_q <= CNT_ZERO;
      gap_cnt_q   <= 16'd0;
      pkt_cnt_q   <= 16'd0;
      to_cnt_q    <= {TW{1'b0}};
      got_to_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      committed_q <= committed_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      got_to_q    <= got_to_d;
    end
  end

  assign txAcceptNewData = tx_accept_s;
  assign sending         = (tx_state_q == TX_RECV);
  assign rxDataValid     = rx_valid_s;
  assign rxData          = rx_valid_s ? head_data_s : {DATA_W{1'b0}};
  assign rxIsLastByte    = rx_valid_s && head_tag_s.last;
  assign keepPacket      = rx_valid_s && head_tag_s.last && !head_tag_s.bad;
  assign gotTimeout      = got_to_q;
  assign pktCount        = pkt_cnt_q;

endmodule

// File: tb/tb_sim_usb_packet_channel.sv
// Self-checking bench for sim_usb_packet_channel (DEPTH=8, GAP_CYCLES=4).
// Expected RX entries are queued when a packet is driven and compared on each RX transfer.
module tb_sim_usb_packet_channel;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int GAP    = 4;
  localparam int TO_CYC = 1024;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              txReqSendPacket, txAcceptNewData, txIsLastByte, txDataValid;
  logic [DATA_W-1:0] txData;
  logic              sending;
  logic              rxAcceptNewData, rxIsLastByte, rxDataValid;
  logic [DATA_W-1:0] rxData;
  logic              keepPacket, resetTimeout, gotTimeout;
  logic [15:0]       pktCount;

  always #5 CLK = ~CLK;

  sim_usb_packet_channel #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .txReqSendPacket(txReqSendPacket), .txAcceptNewData(txAcceptNewData),
    .txIsLastByte(txIsLastByte), .txDataValid(txDataValid), .txData(txData),
    .sending(sending),
    .rxAcceptNewData(rxAcceptNewData), .rxIsLastByte(rxIsLastByte),
    .rxDataValid(rxDataValid), .rxData(rxData), .keepPacket(keepPacket),
    .resetTimeout(resetTimeout), .gotTimeout(gotTimeout), .pktCount(pktCount)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              keep;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] pkt[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;
  int                rx_mode = 1;        // 0: sink stalled, 1: always ready, 2: toggling
  logic              rx_toggle = 1'b0;
  logic              tx_took = 1'b0;
  logic              rx_in_pkt = 1'b0;
  logic              hold_valid = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;
  int                tx_last_cyc = 0, rx_first_cyc = 0, rx_prev_last_cyc = 0, gap_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive sink ready, observe handshakes before the edge, then advance.
  task automatic tick();
    exp_t e;
    case (rx_mode)
      0:       rxAcceptNewData = 1'b0;
      1:       rxAcceptNewData = 1'b1;
      default: begin rx_toggle = ~rx_toggle; rxAcceptNewData = rx_toggle; end
    endcase
    #1;
    if (hold_valid && rxDataValid) check_eq("rx_hold_stable", rxData, hold_data);
    hold_valid = rxDataValid && !rxAcceptNewData;
    hold_data  = rxData;
    if (rxDataValid && !rx_in_pkt) begin
      rx_in_pkt    = 1'b1;
      rx_first_cyc = cyc;
      gap_seen     = cyc - rx_prev_last_cyc - 1;
    end
    if (rxDataValid && rxAcceptNewData) begin
      if (exp_q.size() == 0) begin
        check_eq("rx_unexpected_byte", rxData, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rx_data", rxData, e.data);
        check_eq("rx_last", rxIsLastByte, e.last);
        check_eq("rx_keep", keepPacket, e.keep);
      end
      if (rxIsLastByte) begin
        rx_in_pkt        = 1'b0;
        rx_prev_last_cyc = cyc;
      end
    end
    tx_took = txAcceptNewData && txDataValid;
    if (tx_took && txIsLastByte) tx_last_cyc = cyc;
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  // Send pkt[]; stop_at < size abandons the packet mid-way. Expectations are queued up front:
  // packets longer than DEPTH (sent into an empty channel) truncate to DEPTH bytes, last one dropped.
  task automatic send_pkt(input int stop_at);
    int n    = pkt.size();
    int kept = (n > DEPTH) ? DEPTH : n;
    int w;
    for (int i = 0; i < kept; i++) begin
      exp_q.push_back('{data: pkt[i], last: (i == kept - 1), keep: (i == kept - 1) && (n <= DEPTH)});
    end
    txReqSendPacket = 1'b1;
    tick();
    txReqSendPacket = 1'b0;
    for (int i = 0; i < n && i < stop_at; i++) begin
      txDataValid  = 1'b1;
      txData       = pkt[i];
      txIsLastByte = (i == n - 1);
      tick();
      w = 0;
      while (!tx_took && w < 200) begin tick(); w++; end
      if (!tx_took) check_eq("tx_accept_timeout", 32'd0, 32'd1);
    end
    txDataValid  = 1'b0;
    txIsLastByte = 1'b0;
    txData       = '0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((exp_q.size() != 0 || rxDataValid) && w < 500) begin tick(); w++; end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    exp_q.delete();
    rx_in_pkt  = 1'b0;
    hold_valid = 1'b0;
  endtask

  initial begin
    int w;
    RST_N = 1'b0; txReqSendPacket = 1'b0; txIsLastByte = 1'b0; txDataValid = 1'b0;
    txData = '0; rxAcceptNewData = 1'b0; resetTimeout = 1'b0;
    #2;
    apply_reset();

    // Reset state
    check_eq("rst_sending", sending, 32'd0);
    check_eq("rst_tx_accept", txAcceptNewData, 32'd0);
    check_eq("rst_rx_valid", rxDataValid, 32'd0);
    check_eq("rst_rx_last", rxIsLastByte, 32'd0);
    check_eq("rst_keep", keepPacket, 32'd0);
    check_eq("rst_timeout", gotTimeout, 32'd0);
    check_eq("rst_pktcount", pktCount, 32'd0);

    // Timeout: flag rises exactly on the TO_CYC-th idle cycle after reset
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    check_eq("timeout_early", gotTimeout, 32'd0);
    tick();
    check_eq("timeout_set", gotTimeout, 32'd1);
    tick();
    check_eq("timeout_sticky", gotTimeout, 32'd1);
    resetTimeout = 1'b1;
    tick();
    resetTimeout = 1'b0;
    check_eq("timeout_clear", gotTimeout, 32'd0);

    // 3-byte packet, sink always ready; first byte GAP+2 cycles after commit
    rx_mode = 1;
    pkt = '{8'h11, 8'h22, 8'h33};
    send_pkt(99);
    drain("pkt3_drain");
    check_eq("pkt3_latency", rx_first_cyc - tx_last_cyc, GAP + 2);
    check_eq("pkt3_count", pktCount, 32'd1);

    // Two back-to-back 5-byte packets: exactly GAP idle cycles between them
    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(99);
    pkt = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_pkt(99);
    drain("b2b_drain");
    check_eq("b2b_gap", gap_seen, GAP);
    check_eq("b2b_count", pktCount, 32'd3);

    // Sink toggling ready: data held while unaccepted, nothing lost or repeated
    rx_mode = 2;
    pkt = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    send_pkt(99);
    drain("toggle_drain");
    check_eq("toggle_count", pktCount, 32'd4);

    // Oversize 12-byte packet into DEPTH=8: 8 bytes, last flagged, keepPacket=0
    rx_mode = 1;
    pkt = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5,
            8'hD6, 8'hD7, 8'hD8, 8'hD9, 8'hDA, 8'hDB};
    send_pkt(99);
    drain("oversize_drain");
    check_eq("oversize_count", pktCount, 32'd5);

    // Reset mid-packet with RX holding a byte
    rx_mode = 0;
    pkt = '{8'hE0, 8'hE1, 8'hE2};
    send_pkt(99);
    w = 0;
    while (!rxDataValid && w < 30) begin tick(); w++; end
    check_eq("midrst_rx_pending", rxDataValid, 32'd1);
    pkt = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    send_pkt(3);
    check_eq("midrst_sending", sending, 32'd1);
    RST_N = 1'b0;
    tick();
    check_eq("midrst_sending_clr", sending, 32'd0);
    check_eq("midrst_rx_valid_clr", rxDataValid, 32'd0);
    check_eq("midrst_pktcount_clr", pktCount, 32'd0);
    RST_N = 1'b1;
    exp_q.delete();
    rx_in_pkt  = 1'b0;
    hold_valid = 1'b0;
    rx_mode = 1;
    pkt = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    send_pkt(99);
    drain("post_rst_drain");
    check_eq("post_rst_count", pktCount, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
